// File: rtl/weight_bias_loader.sv
// rtl/weight_bias_loader.sv - streams one layer's weights and biases from parameter RAM to its neurons
// One start loads one layer: a read issue FSM followed by a two-stage registered data path.
module weight_bias_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       layer_num,
  input  logic [CNT_W-1:0]  num_neurons,
  input  logic [CNT_W-1:0]  num_weights,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              weightValid,
  output logic              biasValid,
  output logic [31:0]       weightValue,
  output logic [31:0]       biasValue,
  output logic [31:0]       config_layer_num,
  output logic [31:0]       config_neuron_num,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  n_lat;
  logic [CNT_W-1:0]  w_lat;
  logic [CNT_W-1:0]  k_idx;
  logic [CNT_W-1:0]  n_idx;
  logic [ADDR_W-1:0] addr;

  logic              rd_d1;
  logic              bias_d1;
  logic [CNT_W-1:0]  nrn_d1;

  logic              word_is_bias;
  logic              last_neuron;
  logic [31:0]       data_sext;

  // Words are contiguous (weights then bias per neuron), so the running
  // address is the n*(W+1)+k accumulator itself.
  assign mem_rd       = (state == ST_ISSUE) && !hold;
  assign mem_addr     = addr;
  assign word_is_bias = (k_idx == w_lat);
  assign last_neuron  = (n_idx == n_lat - CNT_W'(1));
  assign data_sext    = {{(32-DATA_W){mem_data[DATA_W-1]}}, mem_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      n_lat             <= '0;
      w_lat             <= '0;
      k_idx             <= '0;
      n_idx             <= '0;
      addr              <= '0;
      rd_d1             <= 1'b0;
      bias_d1           <= 1'b0;
      nrn_d1            <= '0;
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      weightValue       <= '0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      // Stage 1: remember what was read while the RAM produces the word.
      rd_d1   <= mem_rd;
      bias_d1 <= mem_rd && word_is_bias;
      nrn_d1  <= n_idx;

      // Stage 2: present the word; neurons cannot stall, so nothing gates this.
      weightValid <= rd_d1 && !bias_d1;
      biasValid   <= rd_d1 && bias_d1;
      weightValue <= (rd_d1 && !bias_d1) ? data_sext : 32'd0;
      biasValue   <= (rd_d1 && bias_d1) ? data_sext : 32'd0;
      if (rd_d1) begin
        config_neuron_num <= {{(32-CNT_W){1'b0}}, nrn_d1};
      end

      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_lat            <= num_neurons;
            w_lat            <= num_weights;
            k_idx            <= '0;
            n_idx            <= '0;
            addr             <= base_addr;
            config_layer_num <= layer_num;
            busy             <= 1'b1;
            state            <= (num_neurons == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!hold) begin
            addr <= addr + ADDR_W'(1);
            if (word_is_bias) begin
              k_idx <= '0;
              n_idx <= n_idx + CNT_W'(1);
              if (last_neuron) begin
                state <= ST_DRAIN;
              end
            end else begin
              k_idx <= k_idx + CNT_W'(1);
            end
          end
        end

        ST_DRAIN: begin
          // The final word is on the output stage when stage 1 empties.
          if (!rd_d1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done              <= 1'b0;
          addr              <= '0;
          k_idx             <= '0;
          n_idx             <= '0;
          config_layer_num  <= '0;
          config_neuron_num <= '0;
          state             <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bias_loader.sv
// tb/tb_weight_bias_loader.sv - self-checking bench for weight_bias_loader
// Scoreboard of expected words filled at start, drained as the DUT emits valids.
module tb_weight_bias_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] layer_num;
  logic [15:0] num_neurons;
  logic [15:0] num_weights;
  logic [15:0] base_addr;
  logic        hold;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ram [0:255];
  logic [48:0] q [$];

  logic        rec_rd   [0:47];
  logic [15:0] rec_addr [0:47];
  logic        rec_wv   [0:47];
  logic        rec_bv   [0:47];
  logic [31:0] rec_nn   [0:47];
  logic [31:0] rec_lay  [0:47];
  logic [31:0] rec_wval [0:47];
  logic [31:0] rec_bval [0:47];
  logic        rec_busy [0:47];
  logic        rec_zero [0:47];
  int          done_cyc;
  int          done_cnt;

  weight_bias_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .layer_num         (layer_num),
    .num_neurons       (num_neurons),
    .num_weights       (num_weights),
    .base_addr         (base_addr),
    .hold              (hold),
    .mem_rd            (mem_rd),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .weightValid       (weightValid),
    .biasValid         (biasValid),
    .weightValue       (weightValue),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous parameter RAM: data the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= ram[mem_addr[7:0]];
  end

  function automatic logic [31:0] sext(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

  task automatic run_load(input int n, input int w, input int base, input int lay,
                          input int hlo, input int hhi, input int rcyc, input int scyc,
                          input int ncyc);
    logic [48:0] e;
    logic [48:0] o;
    logic [31:0] other;
    int          a;
    q.delete();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k <= w; k++) begin
        a = base + i * (w + 1) + k;
        q.push_back({(k == w), 16'(i), sext(ram[a[7:0]])});
      end
    end
    for (int c = 0; c < 48; c++) begin
      rec_rd[c] = 0; rec_addr[c] = 0; rec_wv[c] = 0; rec_bv[c] = 0; rec_nn[c] = 0;
      rec_lay[c] = 0; rec_wval[c] = 0; rec_bval[c] = 0; rec_busy[c] = 0; rec_zero[c] = 0;
    end
    done_cyc    = -1;
    done_cnt    = 0;
    num_neurons = 16'(n);
    num_weights = 16'(w);
    base_addr   = 16'(base);
    layer_num   = 32'(lay);
    hold        = 1'b0;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      hold  = (c >= hlo) && (c <= hhi);
      rst   = (c == rcyc);
      start = (c == scyc);
      if (c == scyc) layer_num = 32'd9;
      #1;
      rec_rd[c]   = mem_rd;   rec_addr[c] = mem_addr;
      rec_wv[c]   = weightValid; rec_bv[c] = biasValid;
      rec_nn[c]   = config_neuron_num; rec_lay[c] = config_layer_num;
      rec_wval[c] = weightValue; rec_bval[c] = biasValue; rec_busy[c] = busy;
      rec_zero[c] = !mem_rd && mem_addr == 0 && !weightValid && !biasValid &&
                    weightValue == 0 && biasValue == 0 && config_layer_num == 0 &&
                    config_neuron_num == 0 && !busy && !done;
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        done_cnt++;
      end
      if (rcyc > 0 && c == rcyc + 1) q.delete();
      if (weightValid || biasValid) begin
        checks++;
        o     = {biasValid, config_neuron_num[15:0], biasValid ? biasValue : weightValue};
        other = biasValid ? weightValue : biasValue;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_extra cyc=%0d got=%h expected=none", c, o);
        end else begin
          e = q.pop_front();
          if (o !== e || (weightValid && biasValid) || other !== 32'd0) begin
            failures++;
            $display("FAIL sb_word cyc=%0d got=%h wv=%b bv=%b other=%h expected=%h",
                     c, o, weightValid, biasValid, other, e);
          end
        end
      end
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_missing got=%0d_left expected=0_left", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_rd !== 0 || mem_addr !== 0 || weightValid !== 0 || biasValid !== 0 ||
        weightValue !== 0 || biasValue !== 0 || config_layer_num !== 0 ||
        config_neuron_num !== 0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset_outputs got rd=%b wv=%b bv=%b busy=%b done=%b expected all 0",
               mem_rd, weightValid, biasValid, busy, done);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic ev_rd, ev_wv, ev_bv;
    run_load(2, 3, 'h10, 3, 0, 0, 0, 0, 13);
    for (int c = 1; c <= 12; c++) begin
      ev_rd = (c <= 8);
      ev_wv = (c >= 3 && c <= 5) || (c >= 7 && c <= 9);
      ev_bv = (c == 6) || (c == 10);
      checks++;
      if (rec_rd[c] !== ev_rd || (ev_rd && rec_addr[c] !== 16'(16 + c - 1))) begin
        failures++;
        $display("FAIL basic_rd cyc=%0d got=%b/%h expected=%b/%h", c, rec_rd[c], rec_addr[c],
                 ev_rd, 16'(16 + c - 1));
      end
      checks++;
      if (rec_wv[c] !== ev_wv || rec_bv[c] !== ev_bv) begin
        failures++;
        $display("FAIL basic_valid cyc=%0d got=%b%b expected=%b%b", c, rec_wv[c], rec_bv[c],
                 ev_wv, ev_bv);
      end
      if (c >= 3 && c <= 10) begin
        checks++;
        if (rec_nn[c] !== ((c >= 7) ? 32'd1 : 32'd0)) begin
          failures++;
          $display("FAIL basic_neuron cyc=%0d got=%0d expected=%0d", c, rec_nn[c], (c >= 7));
        end
      end
      if (c <= 10) begin
        checks++;
        if (rec_busy[c] !== 1'b1 || rec_lay[c] !== 32'd3) begin
          failures++;
          $display("FAIL basic_busy_layer cyc=%0d got=%b/%0d expected=1/3", c, rec_busy[c], rec_lay[c]);
        end
      end
    end
    checks++;
    if (done_cyc != 11 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done got=cyc%0d_x%0d expected=cyc11_x1", done_cyc, done_cnt);
    end
    checks++;
    if (rec_wval[3] !== 32'hFFFF8001) begin
      failures++;
      $display("FAIL sext_weight got=%h expected=FFFF8001", rec_wval[3]);
    end
    checks++;
    if (rec_bval[6] !== 32'h00007FFF) begin
      failures++;
      $display("FAIL sext_bias got=%h expected=00007FFF", rec_bval[6]);
    end
    checks++;
    if (rec_zero[12] !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle_zero got=%b expected=1", rec_zero[12]);
    end
  endtask

  task automatic test_hold();
    int ea, nw, nb;
    logic ev_rd;
    run_load(2, 3, 'h10, 3, 4, 5, 0, 0, 15);
    ea = 'h10; nw = 0; nb = 0;
    for (int c = 1; c <= 15; c++) begin
      ev_rd = (c <= 3) || (c >= 6 && c <= 10);
      checks++;
      if (rec_rd[c] !== ev_rd || (ev_rd && rec_addr[c] !== 16'(ea))) begin
        failures++;
        $display("FAIL hold_rd cyc=%0d got=%b/%h expected=%b/%h", c, rec_rd[c], rec_addr[c], ev_rd, 16'(ea));
      end
      if (ev_rd) ea++;
      if (rec_wv[c]) nw++;
      if (rec_bv[c]) nb++;
    end
    checks++;
    if (nw != 6 || nb != 2) begin
      failures++;
      $display("FAIL hold_counts got=%0dw_%0db expected=6w_2b", nw, nb);
    end
    checks++;
    if (done_cyc != 13 || done_cnt != 1) begin
      failures++;
      $display("FAIL hold_done got=cyc%0d_x%0d expected=cyc13_x1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int late;
    run_load(2, 3, 'h10, 3, 0, 0, 6, 0, 14);
    checks++;
    if (rec_zero[7] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_zero got rd=%b wv=%b bv=%b busy=%b expected all 0",
               rec_rd[7], rec_wv[7], rec_bv[7], rec_busy[7]);
    end
    late = 0;
    for (int c = 7; c <= 14; c++) if (rec_wv[c] || rec_bv[c] || rec_rd[c]) late++;
    checks++;
    if (late != 0 || done_cnt != 0) begin
      failures++;
      $display("FAIL midrst_quiet got=%0dact_%0ddone expected=0act_0done", late, done_cnt);
    end
    run_load(2, 3, 'h10, 3, 0, 0, 0, 0, 13);
    checks++;
    if (done_cyc != 11 || rec_rd[1] !== 1'b1 || rec_addr[1] !== 16'h0010) begin
      failures++;
      $display("FAIL midrst_reload got=cyc%0d/%h expected=cyc11/0010", done_cyc, rec_addr[1]);
    end
  endtask

  task automatic test_start_busy();
    int bad;
    run_load(2, 3, 'h10, 3, 0, 0, 0, 5, 13);
    bad = 0;
    for (int c = 1; c <= 10; c++) if (rec_lay[c] !== 32'd3) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL busy_start_layer got=%0d_bad_cycles lay10=%0d expected=0_bad 3", bad, rec_lay[10]);
    end
    checks++;
    if (done_cyc != 11 || done_cnt != 1) begin
      failures++;
      $display("FAIL busy_start_done got=cyc%0d_x%0d expected=cyc11_x1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_zero_neurons();
    int act;
    run_load(0, 3, 'h20, 5, 0, 0, 0, 0, 5);
    act = 0;
    for (int c = 1; c <= 5; c++) if (rec_rd[c] || rec_wv[c] || rec_bv[c]) act++;
    checks++;
    if (done_cyc != 2 || done_cnt != 1 || act != 0 || rec_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL zero_neurons got=cyc%0d_x%0d_act%0d_busy%b expected=cyc2_x1_act0_busy1",
               done_cyc, done_cnt, act, rec_busy[1]);
    end
  endtask

  task automatic test_zero_weights();
    run_load(3, 0, 'h40, 7, 0, 0, 0, 0, 8);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (rec_wv[c] !== 1'b0 || rec_bv[c] !== (c >= 3 && c <= 5) ||
          (c >= 3 && c <= 5 && rec_nn[c] !== 32'(c - 3)) ||
          (c <= 3 && rec_addr[c] !== 16'('h40 + c - 1))) begin
        failures++;
        $display("FAIL zero_weights cyc=%0d got wv=%b bv=%b nn=%0d addr=%h expected wv=0 bv=%b nn=%0d",
                 c, rec_wv[c], rec_bv[c], rec_nn[c], rec_addr[c], (c >= 3 && c <= 5), c - 3);
      end
    end
    checks++;
    if (done_cyc != 6) begin
      failures++;
      $display("FAIL zero_weights_done got=%0d expected=6", done_cyc);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; layer_num = 0;
    num_neurons = 0; num_weights = 0; base_addr = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    ram['h10] = 16'h8001;
    ram['h13] = 16'h7FFF;
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_start_busy();
    test_zero_neurons();
    test_zero_weights();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
